// File: rtl/riscv_v_bw_reduct_accum_pkg.sv
// Shared vector-unit definitions used by the bitwise reduction accumulator.
package riscv_v_pkg;

  localparam int unsigned RISCV_V_DATA_WIDTH        = 128;
  localparam int unsigned RISCV_V_NUM_VALID_OSIZES  = 5;
  localparam int unsigned RISCV_V_MAX_LMUL          = 8;

  // One-hot bit positions of the element-size vector
  localparam int unsigned RISCV_V_OSIZE_8   = 0;
  localparam int unsigned RISCV_V_OSIZE_16  = 1;
  localparam int unsigned RISCV_V_OSIZE_32  = 2;
  localparam int unsigned RISCV_V_OSIZE_64  = 3;
  localparam int unsigned RISCV_V_OSIZE_128 = 4;

  typedef enum logic [1:0] {
    BW_AND = 2'b00,
    BW_OR  = 2'b01,
    BW_XOR = 2'b10
  } bw_op_t;

  // Raw op field to operation; the reserved encoding behaves as OR
  function automatic bw_op_t decode_bw_op(input logic [1:0] op);
    bw_op_t res;
    case (op)
      2'b00:   res = BW_AND;
      2'b10:   res = BW_XOR;
      default: res = BW_OR;
    endcase
    return res;
  endfunction

  // Lowest set bit selects the element width; an empty vector means 8 bits
  function automatic logic [RISCV_V_DATA_WIDTH-1:0] osize_to_mask(
    input logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize_vector
  );
    logic [RISCV_V_DATA_WIDTH-1:0] m;
    m = '0;
    if (osize_vector[RISCV_V_OSIZE_8])        m[7:0]   = '1;
    else if (osize_vector[RISCV_V_OSIZE_16])  m[15:0]  = '1;
    else if (osize_vector[RISCV_V_OSIZE_32])  m[31:0]  = '1;
    else if (osize_vector[RISCV_V_OSIZE_64])  m[63:0]  = '1;
    else if (osize_vector[RISCV_V_OSIZE_128]) m        = '1;
    else                                      m[7:0]   = '1;
    return m;
  endfunction

endpackage

// File: rtl/riscv_v_bw_reduct_accum_combine.sv
// Combinational bitwise fold of two operands, truncated to the element width.
module riscv_v_bw_combine
  import riscv_v_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RISCV_V_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  bw_op_t                op_i,
  input  logic [DATA_WIDTH-1:0] mask_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  // Apply the selected operation, then clear bits above the element
  always_comb begin
    res_o = '0;
    case (op_i)
      BW_AND:  res_o = (a_i & b_i) & mask_i;
      BW_XOR:  res_o = (a_i ^ b_i) & mask_i;
      default: res_o = (a_i | b_i) & mask_i;
    endcase
  end

endmodule

// File: rtl/riscv_v_bw_reduct_accum.sv
// Folds the per-register bitwise results of an LMUL group plus the vs1[0]
// scalar into one reduction result handed to writeback.
module riscv_v_bw_reduct_accum
  import riscv_v_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RISCV_V_DATA_WIDTH,
  parameter int unsigned MAX_BEATS  = RISCV_V_MAX_LMUL,
  parameter int unsigned NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [1:0]            op,
  input  logic [NUM_OSIZES-1:0] osize_vector,
  input  logic [DATA_WIDTH-1:0] init_scalar,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  bw_op_t                op_q, op_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;

  logic                  accept;
  bw_op_t                op_first;
  logic [DATA_WIDTH-1:0] mask_first;
  logic [DATA_WIDTH-1:0] res_first;
  logic [DATA_WIDTH-1:0] res_fold;
  logic [CNT_W-1:0]      beat_cnt_inc;

  assign op_first   = decode_bw_op(op);
  assign mask_first = DATA_WIDTH'(osize_to_mask(RISCV_V_NUM_VALID_OSIZES'(osize_vector)));

  // First beat folds against the incoming scalar with freshly sampled op/size
  riscv_v_bw_combine #(.DATA_WIDTH(DATA_WIDTH)) u_combine_first (
    .a_i    (init_scalar),
    .b_i    (in_data),
    .op_i   (op_first),
    .mask_i (mask_first),
    .res_o  (res_first)
  );

  // Later beats fold against the accumulator with the latched op/size
  riscv_v_bw_combine #(.DATA_WIDTH(DATA_WIDTH)) u_combine_fold (
    .a_i    (acc_q),
    .b_i    (in_data),
    .op_i   (op_q),
    .mask_i (mask_q),
    .res_o  (res_fold)
  );

  assign in_ready     = (state_q != ST_DONE);
  assign accept       = in_valid & in_ready;
  assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);

  assign out_valid = (state_q == ST_DONE);
  assign out_data  = (state_q == ST_DONE) ? acc_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

  // Next-state and datapath update for the reduction sequencer
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mask_d     = mask_q;
    op_d       = op_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          if (in_first) begin
            // A first beat mid-group flags an error but restarts cleanly
            if (state_q == ST_ACCUM) err_d = 1'b1;
            acc_d      = res_first;
            op_d       = op_first;
            mask_d     = mask_first;
            beat_cnt_d = CNT_W'(1);
            state_d    = in_last ? ST_DONE : ST_ACCUM;
          end else if (state_q == ST_IDLE) begin
            err_d = 1'b1;
          end else begin
            acc_d      = res_fold;
            beat_cnt_d = beat_cnt_inc;
            if (in_last || (beat_cnt_inc == CNT_MAX)) state_d = ST_DONE;
            if (!in_last && (beat_cnt_inc == CNT_MAX)) err_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and accumulator registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      mask_q     <= '0;
      op_q       <= BW_AND;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mask_q     <= mask_d;
      op_q       <= op_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_riscv_v_bw_reduct_accum.sv
// Directed bench for the bitwise reduction accumulator.
module tb_riscv_v_bw_reduct_accum;

  localparam int unsigned DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_first;
  logic          in_last;
  logic [1:0]    op;
  logic [4:0]    osize_vector;
  logic [DW-1:0] init_scalar;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  riscv_v_bw_reduct_accum #(
    .DATA_WIDTH (128),
    .MAX_BEATS  (8),
    .NUM_OSIZES (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_first     (in_first),
    .in_last      (in_last),
    .op           (op),
    .osize_vector (osize_vector),
    .init_scalar  (init_scalar),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and wait (bounded) until it is accepted
  task automatic send_beat(input logic first, input logic last,
                           input logic [DW-1:0] init, input logic [DW-1:0] data);
    int unsigned waited;
    waited      = 0;
    in_valid    = 1'b1;
    in_first    = first;
    in_last     = last;
    init_scalar = init;
    in_data     = data;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Complete the result handshake and confirm the block returns to idle
  task automatic take_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_first = 0; in_last = 0; op = 2'b01;
    osize_vector = 5'b00001; init_scalar = '0; in_data = '0; out_ready = 0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);

    // OR, 8b, single beat; result visible the cycle after acceptance
    op = 2'b01; osize_vector = 5'b00001;
    send_beat(1, 1, 128'h01, 128'h80);
    chk("or8_valid", out_valid, 1);
    chk("or8_data", out_data, 128'h81);
    chk("or8_in_ready", in_ready, 0);
    chk("or8_err", err, 0);
    take_result("or8");

    // XOR, 32b, 4 beats; garbage above 32 bits must vanish
    op = 2'b10; osize_vector = 5'b00100;
    send_beat(1, 0, {96'hDEAD_BEEF_0000_1111_2222_3333, 32'hFFFF0000}, 128'h0000FFFF);
    chk("xor32_mid_valid", out_valid, 0);
    chk("xor32_mid_busy", busy, 1);
    send_beat(0, 0, '0, {96'hAAAA, 32'h12345678});
    send_beat(0, 0, '0, 128'h12345678);
    send_beat(0, 1, '0, 128'h00000000);
    chk("xor32_data", out_data, 128'hFFFFFFFF);
    take_result("xor32");

    // AND, 16b, 2 beats with writeback stalled and a beat waiting upstream
    op = 2'b00; osize_vector = 5'b00010;
    send_beat(1, 0, 128'hFFFF, 128'hF0F0);
    send_beat(0, 1, '0, 128'h3C3C);
    in_valid = 1; in_first = 1; in_last = 1; init_scalar = 128'h7; in_data = 128'h7;
    for (int i = 0; i < 5; i++) begin
      chk("and16_hold_valid", out_valid, 1);
      chk("and16_hold_data", out_data, 128'h3030);
      chk("and16_hold_ready", in_ready, 0);
      tick();
    end
    in_valid = 0; in_first = 0; in_last = 0;
    take_result("and16");

    // Reserved op behaves as OR: 0x0C | 0x06 = 0x0E (XOR would give 0x0A)
    op = 2'b11; osize_vector = 5'b00001;
    send_beat(1, 1, 128'h0C, 128'h06);
    chk("rsvd_or_data", out_data, 128'h0E);
    take_result("rsvd");

    // Empty osize vector means 8b
    op = 2'b01; osize_vector = 5'b00000;
    send_beat(1, 1, 128'h1FF, 128'h100);
    chk("osz0_data", out_data, 128'hFF);
    take_result("osz0");

    // Multiple bits set: lowest wins (16b)
    op = 2'b01; osize_vector = 5'b10010;
    send_beat(1, 1, 128'h1_2345, 128'h0);
    chk("oszmulti_data", out_data, 128'h2345);
    take_result("oszmulti");

    // AND, 128b full width
    op = 2'b00; osize_vector = 5'b10000;
    send_beat(1, 1, '1, 128'h8000_0000_0000_0000_0000_0000_0000_0001);
    chk("and128_data", out_data, 128'h8000_0000_0000_0000_0000_0000_0000_0001);
    chk("clean_err", err, 0);
    take_result("and128");

    // Non-first beat in IDLE is dropped and flags an error
    send_beat(0, 1, 128'h55, 128'h55);
    chk("idle_drop_err", err, 1);
    chk("idle_drop_busy", busy, 0);
    chk("idle_drop_valid", out_valid, 0);
    do_reset();
    chk("err_cleared_by_rst", err, 0);

    // Group without last closes after 8 beats; a 9th beat would set bit 8
    op = 2'b01; osize_vector = 5'b00010;
    send_beat(1, 0, '0, 128'h1);
    for (int i = 1; i < 8; i++) send_beat(0, 0, '0, 128'h1 << i);
    chk("max_valid", out_valid, 1);
    chk("max_data", out_data, 128'hFF);
    chk("max_err", err, 1);
    in_valid = 1; in_data = 128'h100;
    tick();
    tick();
    chk("max_no_9th_ready", in_ready, 0);
    chk("max_no_9th_data", out_data, 128'hFF);
    in_valid = 0;
    take_result("max");
    do_reset();

    // Restart mid-group: first beat in ACCUM reloads scalar and op
    op = 2'b01; osize_vector = 5'b00001;
    send_beat(1, 0, 128'h10, 128'h01);
    send_beat(0, 0, '0, 128'h02);
    chk("restart_pre_err", err, 0);
    send_beat(1, 1, 128'h05, 128'h00);
    chk("restart_data", out_data, 128'h05);
    chk("restart_err", err, 1);
    take_result("restart");
    do_reset();

    // Reset while accumulating discards the partial result
    op = 2'b01; osize_vector = 5'b00001;
    send_beat(1, 0, 128'hF0, 128'h0F);
    chk("mid_busy", busy, 1);
    do_reset();
    chk("rst_accum_busy", busy, 0);
    chk("rst_accum_valid", out_valid, 0);
    chk("rst_accum_ready", in_ready, 1);
    op = 2'b10; osize_vector = 5'b00001;
    send_beat(1, 1, 128'hAA, 128'h0F);
    chk("post_rst_data", out_data, 128'hA5);
    take_result("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_v_bw_reduct_accum.md
Name: riscv_v_bw_reduct_accum

Overview:
- Sequential accumulator directly downstream of the bitwise OR/AND/XOR byte-lane units.
- Consumes one 128-bit result beat per accepted handshake. Each beat has already been reduced within its 128-bit register to the lowest element of the current osize.
- Folds beats of an LMUL register group (up to MAX_BEATS) plus the vs1[0] initial scalar into one scalar reduction result.
- Presents that result to writeback over a valid/ready handshake.

Parameters:
- DATA_WIDTH, 128, beat/result width (= RISCV_V_DATA_WIDTH)
- MAX_BEATS, 8, maximum beats per reduction (LMUL=8)
- NUM_OSIZES, 5, one-hot osize encodings (8/16/32/64/128)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block can accept a beat
- in_first  in  1  beat is first of a reduction; init_scalar sampled with it
- in_last  in  1  beat is last of a reduction
- op  in  2  00 AND, 01 OR, 10 XOR, 11 reserved (treated as OR); sampled on first beat
- osize_vector  in  NUM_OSIZES  one-hot element size, bit0=8b … bit4=128b; sampled on first beat
- init_scalar  in  DATA_WIDTH  vs1 element 0
- in_data  in  DATA_WIDTH  reduced beat from bitwise unit; element in low osize bits
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts result
- out_data  out  DATA_WIDTH  scalar result, zero-extended above osize
- busy  out  1  FSM not IDLE
- err  out  1  sticky protocol error; cleared only by rst

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, acc=0, beat_cnt=0, out_valid=0, out_data=0, err=0, busy=0. Any in-flight reduction is discarded.
- Accept = in_valid & in_ready.
- in_ready=1 in IDLE and ACCUM, 0 in DONE. There is no same-cycle pass-through from DONE.
- Size mask: width = lowest set bit of osize_vector. osize_vector==0 is treated as 8b.
- op, size mask and beat data are combined as acc_next = (A op B) & size_mask.
- IDLE:
  - Accept with in_first=1: latch op and size; acc = init_scalar op in_data; beat_cnt=1.
  - If in_last=1 -> DONE, else -> ACCUM.
  - Accept with in_first=0: beat is dropped, err<=1, state stays IDLE.
- ACCUM:
  - Accept with in_first=0: acc = acc op in_data; beat_cnt++.
  - If in_last=1, or beat_cnt reaches MAX_BEATS -> DONE. Reaching MAX_BEATS without in_last sets err<=1.
  - Accept with in_first=1: err<=1; accumulation restarts exactly as in IDLE (new init_scalar, op, size).
- DONE:
  - out_valid=1 and out_data=acc, both held stable until out_ready=1.
  - On out_valid & out_ready: out_valid<=0, beat_cnt<=0, state -> IDLE.
- Latency: last beat accepted at cycle N gives out_valid=1 at N+1 at the earliest.
- Throughput: one beat/cycle while accumulating. After a result handshake in cycle M, the next first beat is accepted at M+1 at the earliest.
- out_data bits above the osize width are always 0. in_data and init_scalar bits above osize are ignored.
- busy = (state != IDLE).

Decomposition:
- Shared package riscv_v_pkg:
  - bw_op_t enum (AND/OR/XOR)
  - RISCV_V_NUM_VALID_OSIZES
  - RISCV_V_DATA_WIDTH
  - RISCV_V_MAX_LMUL
  - the osize one-hot bit positions
  - function osize_to_mask(osize_vector) returning a DATA_WIDTH mask
- One sub-module: riscv_v_bw_combine, purely combinational.
  - Inputs: A, B, op, mask.
  - Output: (A op B) & mask.
  - Reused for both the first-beat and steady-state fold paths.

Test Plan:
- OR, 8b, 1 beat: init_scalar=0x01, in_data=0x80, first=last=1 -> out_valid next cycle, out_data=0x81, err=0.
- XOR, 32b, 4 beats:
  - init=0xFFFF0000; data = 0x0000FFFF, 0x12345678, 0x12345678, 0x00000000.
  - Required: out_data=0xFFFFFFFF, upper 96 bits 0.
- AND, 16b, 2 beats: init=0xFFFF, data 0xF0F0 then 0x3C3C with out_ready held 0 for 5 cycles -> out_valid held, out_data=0x3030 stable, in_ready=0, no new beat accepted.
- Protocol error, two cases:
  - Beat with in_first=0 in IDLE -> dropped, err=1.
  - 9 beats without in_last -> DONE after beat 8, err=1, result covers 8 beats only.
- Restart and reset:
  - OR reduction mid-group; in_first=1 beat with init=0x5, data=0x0, last=1 -> out_data=0x5, err=1.
  - rst asserted in ACCUM -> next cycle state IDLE, out_valid=0, busy=0.
- Size masking: osize_vector=5'b00000, init=0x1FF, data=0x100, OR, single beat -> out_data=0xFF.
